// File: rtl/mini_core_pkg.sv
// Shared definitions for the mini-core: widths, opcodes, execute-stage states
// and the single-cycle ALU helper.
package mini_core_pkg;

  localparam int DATA_W    = 6;
  localparam int ADR_W     = 6;
  localparam int MUL_STEPS = DATA_W;
  localparam int CNT_W     = $clog2(MUL_STEPS);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    HALT = 2'b10
  } state_t;

  // Single-cycle ALU; results wrap modulo 2^DATA_W, MUL is handled elsewhere.
  function automatic logic [DATA_W-1:0] alu_single(input logic [1:0]        op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_wb_if.sv
// Bundle between load stage / data memory and the execute/write-back stage.
interface ex_wb_if;
  import mini_core_pkg::*;

  logic              halted;
  logic [ADR_W-1:0]  write_adr;
  logic [1:0]        alu_inst;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  logic              data_mem_write;
  logic              freeze;
  logic              mem_wr_en;
  logic [ADR_W-1:0]  mem_wr_adr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              core_halted;

  // Execute stage side.
  modport slave (
    input  halted, write_adr, alu_inst, data_1, data_2, data_mem_write,
    output freeze, mem_wr_en, mem_wr_adr, mem_wr_data, core_halted
  );

  // Load stage / environment side.
  modport master (
    output halted, write_adr, alu_inst, data_1, data_2, data_mem_write,
    input  freeze, mem_wr_en, mem_wr_adr, mem_wr_data, core_halted
  );

endinterface

// File: rtl/ex_wb_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, MUL_STEPS
// cycles after start. done/product are valid combinationally on the last step
// so the caller can register the result on that same edge.
module mul_seq
  import mini_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [DATA_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;
  logic [DATA_W-1:0] addend_s;
  logic [DATA_W-1:0] sum_s;
  logic              last_s;

  // Partial-product add for the current multiplier bit.
  always_comb begin
    addend_s = {DATA_W{1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {DATA_W{1'b0}};
    end
    sum_s  = acc_r + addend_s;
    last_s = busy_r && (cnt_r == LAST_STEP);
  end

  // Iteration state: load on start, then shift/accumulate until the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r  <= {DATA_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
      cnt_r    <= CNT_ZERO;
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {DATA_W{1'b0}};
      cnt_r    <= CNT_ZERO;
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= sum_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (last_s) begin
        cnt_r  <= CNT_ZERO;
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + CNT_ONE;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign busy    = busy_r;
  assign done    = last_s;
  assign product = sum_s;

endmodule

// File: rtl/ex_wb.sv
// Execute/write-back stage: single-cycle ALU ops retire the cycle after
// capture, MUL runs on the iterative multiplier while freezing the load stage,
// HALT parks the stage until reset.
module ex_wb
  import mini_core_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  ex_wb_if.slave  bus
);

  state_t            state_r;
  state_t            state_nxt;
  logic              wr_en_r;
  logic [ADR_W-1:0]  wr_adr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              halted_r;
  logic [ADR_W-1:0]  mul_adr_r;

  logic              wr_en_nxt;
  logic [ADR_W-1:0]  wr_adr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic              halted_nxt;
  logic [ADR_W-1:0]  mul_adr_nxt;
  logic              mul_start_s;

  logic              mul_busy_s;
  logic              mul_done_s;
  logic [DATA_W-1:0] mul_product_s;

  mul_seq u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (bus.data_1),
    .b       (bus.data_2),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state: halt beats everything, MUL waits for the multiplier's last step.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (bus.halted) begin
          state_nxt = HALT;
        end else if (bus.data_mem_write && (bus.alu_inst == OP_MUL)) begin
          state_nxt = MUL;
        end else begin
          state_nxt = IDLE;
        end
      end
      MUL: begin
        // A multiplier that is no longer busy cannot finish; recover to IDLE.
        if (mul_done_s || !mul_busy_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = MUL;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the write port, halt flag and MUL capture.
  always_comb begin
    wr_en_nxt   = 1'b0;
    wr_adr_nxt  = wr_adr_r;
    wr_data_nxt = wr_data_r;
    halted_nxt  = halted_r;
    mul_adr_nxt = mul_adr_r;
    mul_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.halted) begin
          halted_nxt = 1'b1;
        end else if (bus.data_mem_write) begin
          if (bus.alu_inst == OP_MUL) begin
            mul_start_s = 1'b1;
            mul_adr_nxt = bus.write_adr;
          end else begin
            wr_en_nxt   = 1'b1;
            wr_adr_nxt  = bus.write_adr;
            wr_data_nxt = alu_single(bus.alu_inst, bus.data_1, bus.data_2);
          end
        end else begin
          wr_en_nxt = 1'b0;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          wr_en_nxt   = 1'b1;
          wr_adr_nxt  = mul_adr_r;
          wr_data_nxt = mul_product_s;
        end else begin
          wr_en_nxt = 1'b0;
        end
      end
      HALT: begin
        halted_nxt = 1'b1;
      end
      default: begin
        wr_en_nxt = 1'b0;
      end
    endcase
  end

  // Registered write port, sticky halt flag and latched MUL destination.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_adr_r  <= {ADR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
      halted_r  <= 1'b0;
      mul_adr_r <= {ADR_W{1'b0}};
    end else begin
      wr_en_r   <= wr_en_nxt;
      wr_adr_r  <= wr_adr_nxt;
      wr_data_r <= wr_data_nxt;
      halted_r  <= halted_nxt;
      mul_adr_r <= mul_adr_nxt;
    end
  end

  assign bus.freeze      = (state_r != IDLE);
  assign bus.mem_wr_en   = wr_en_r;
  assign bus.mem_wr_adr  = wr_adr_r;
  assign bus.mem_wr_data = wr_data_r;
  assign bus.core_halted = halted_r;

endmodule
